bram_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one single-port BRAM (1-cycle read latency) between
//   NUM_REQ requesters inside design_1. Grants one requester at a time for a burst of
//   up to MAX_BURST beats, muxes its address/data onto the BRAM port and routes read

---
 rtl/bram_rr_arbiter_if.sv | 37 +++
 rtl/bram_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_bram_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : bram_rr_arbiter_if
// Brief   : Requester-side and BRAM-side bus bundle for bram_rr_arbiter.
// Revision: 1.0  initial release
// ============================================================================
interface bram_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic                      bram_en;
  logic                      bram_we;
  logic [ADDR_W-1:0]         bram_addr;
  logic [DATA_W-1:0]         bram_wdata;
  logic [DATA_W-1:0]         bram_rdata;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;

  // Arbiter side
  modport slave (
    input  req, req_we, req_addr, req_wdata, bram_rdata,
    output gnt, bram_en, bram_we, bram_addr, bram_wdata, rd_valid, rd_data
  );

  // Requester/BRAM environment side
  modport master (
    output req, req_we, req_addr, req_wdata, bram_rdata,
    input  gnt, bram_en, bram_we, bram_addr, bram_wdata, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/bram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bram_rr_arbiter
// Brief   : Round-robin burst arbiter sharing one single-port BRAM between
//           NUM_REQ requesters. Optional macro ARB_PRIO0_EN gives requester 0
//           absolute priority at grant time.
// Revision: 1.0  initial release
// ============================================================================
module bram_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  wire logic          sys_clock,
  input  wire logic          reset_rtl,
  bram_rr_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0] r_rd_valid, w_rd_valid_nxt;
  logic [IDX_W-1:0]   r_winner, w_winner_nxt;
  logic [IDX_W-1:0]   r_last_winner, w_last_winner_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;

  logic               w_sel_found;
  logic [IDX_W-1:0]   w_sel;
  logic               w_prio0;
  logic               w_beat;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;

`ifdef ARB_PRIO0_EN
  assign w_prio0 = bus.req[0];
`else
  assign w_prio0 = 1'b0;
`endif

  // Scan backwards so the candidate closest after last_winner is written last and wins.
  always_comb begin
    w_sel       = '0;
    w_sel_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[(int'(r_last_winner) + k) % NUM_REQ]) begin
        w_sel       = IDX_W'((int'(r_last_winner) + k) % NUM_REQ);
        w_sel_found = 1'b1;
      end
    end
    if (w_prio0) begin
      w_sel = '0;
    end
  end

  assign w_beat  = (r_state == ST_BUSY) & r_gnt[r_winner] & bus.req[r_winner];
  assign w_we    = w_beat & bus.req_we[r_winner];
  assign w_addr  = bus.req_addr[int'(r_winner)*ADDR_W +: ADDR_W];
  assign w_wdata = bus.req_wdata[int'(r_winner)*DATA_W +: DATA_W];

  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_nxt         = r_gnt;
    w_winner_nxt      = r_winner;
    w_last_winner_nxt = r_last_winner;
    w_beat_cnt_nxt    = r_beat_cnt;
    w_rd_valid_nxt    = '0;

    // Read data arrives one cycle later; the strobe follows even if the grant drops.
    if (w_beat && !w_we) begin
      w_rd_valid_nxt[r_winner] = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (w_sel_found) begin
          w_state_nxt         = ST_BUSY;
          w_gnt_nxt[w_sel]    = 1'b1;
          w_winner_nxt        = w_sel;
          w_beat_cnt_nxt      = '0;
          if (!w_prio0) begin
            w_last_winner_nxt = w_sel;
          end
        end
      end
      ST_BUSY: begin
        if (!bus.req[r_winner]) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end else begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (r_beat_cnt == CNT_W'(MAX_BURST - 1)) begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      r_state       <= ST_IDLE;
      r_gnt         <= '0;
      r_rd_valid    <= '0;
      r_winner      <= '0;
      r_last_winner <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_gnt_nxt;
      r_rd_valid    <= w_rd_valid_nxt;
      r_winner      <= w_winner_nxt;
      r_last_winner <= w_last_winner_nxt;
      r_beat_cnt    <= w_beat_cnt_nxt;
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.bram_en    = w_beat;
  assign bus.bram_we    = w_we;
  assign bus.bram_addr  = w_beat ? w_addr  : '0;
  assign bus.bram_wdata = w_beat ? w_wdata : '0;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = bus.bram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_rr_arbiter
// Brief   : Directed plus randomized bench for bram_rr_arbiter against a
//           transaction-level ownership model and a sparse memory shadow.
// Revision: 1.0  initial release
// ============================================================================
module tb_bram_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 8;

  logic clk;
  logic rst_n;

  logic [N-1:0]  req_v;
  logic [N-1:0]  we_v;
  logic [AW-1:0] addr_v  [N];
  logic [DW-1:0] wdata_v [N];
  logic [DW-1:0] bram_q;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  bram_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .sys_clock (clk),
    .reset_rtl (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.req        = req_v;
  assign bus.req_we     = we_v;
  assign bus.bram_rdata = bram_q;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = addr_v[i];
      bus.req_wdata[i*DW +: DW] = wdata_v[i];
    end
  end

  // Single-port BRAM, one-cycle read latency
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
      else             bram_q <= mem[bus.bram_addr];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: who owns the BRAM, how many beats they have used, who won last
  int             m_owner;
  int             m_used;
  int             m_lw;
  int             m_rd_owner;
  bit             m_rd_known;
  logic [DW-1:0]  m_rd_exp;
  logic [DW-1:0]  m_mem [int];
  bit             m_beat;

  logic [N-1:0]   obs_gnt;
  logic [N-1:0]   obs_rv;
  logic [DW-1:0]  obs_rd;
  int             n_writes;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_used     = 0;
    m_lw       = N - 1;
    m_rd_owner = -1;
    m_rd_known = 0;
  endtask

  // Entered just after a rising edge with inputs already set; leaves just after the next one.
  task automatic run_cycle();
    logic [N-1:0] eg, erv;
    bit found;
    int a, idx;
    @(negedge clk);
    eg  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    erv = (m_rd_owner >= 0) ? N'(1 << m_rd_owner) : '0;
    m_beat = (m_owner >= 0) && req_v[m_owner];
    check("gnt", 64'(bus.gnt), 64'(eg));
    check("bram_en", 64'(bus.bram_en), 64'(m_beat));
    check("bram_we", 64'(bus.bram_we), 64'(m_beat && we_v[m_owner]));
    if (m_beat) begin
      check("bram_addr", 64'(bus.bram_addr), 64'(addr_v[m_owner]));
      if (we_v[m_owner]) check("bram_wdata", 64'(bus.bram_wdata), 64'(wdata_v[m_owner]));
    end
    check("rd_valid", 64'(bus.rd_valid), 64'(erv));
    if (m_rd_owner >= 0 && m_rd_known) check("rd_data", 64'(bus.rd_data), 64'(m_rd_exp));
    obs_gnt = bus.gnt;
    obs_rv  = bus.rd_valid;
    obs_rd  = bus.rd_data;
    if (bus.bram_en && bus.bram_we) n_writes++;

    @(posedge clk);
    #1;
    m_rd_owner = -1;
    if (m_beat) begin
      a = int'(addr_v[m_owner]);
      if (we_v[m_owner]) begin
        m_mem[a] = wdata_v[m_owner];
      end else begin
        m_rd_owner = m_owner;
        m_rd_known = m_mem.exists(a);
        if (m_rd_known) m_rd_exp = m_mem[a];
      end
    end
    if (m_owner < 0) begin
      found = 0;
`ifdef ARB_PRIO0_EN
      if (req_v[0]) begin
        m_owner = 0;
        found   = 1;
      end
`endif
      for (int k = 1; k <= N && !found; k++) begin
        idx = (m_lw + k) % N;
        if (req_v[idx]) begin
          m_owner = idx;
          m_lw    = idx;
          found   = 1;
        end
      end
      m_used = 0;
    end else if (!req_v[m_owner]) begin
      m_owner = -1;
    end else begin
      m_used++;
      if (m_used == MB) m_owner = -1;
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_bram_en", 64'(bus.bram_en), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_idle(input int cycles);
    req_v = '0;
    we_v  = '0;
    for (int i = 0; i < cycles; i++) run_cycle();
  endtask

  initial begin
    rst_n   = 1'b0;
    req_v   = '0;
    we_v    = '0;
    for (int i = 0; i < N; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
    model_reset();
    m_beat   = 0;
    n_writes = 0;
    @(posedge clk);
    #1;
    check("reset_gnt", 64'(bus.gnt), 64'd0);
    check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("reset_bram_en", 64'(bus.bram_en), 64'd0);
    rst_n = 1'b1;

    // All four requesting: 0,1,2,3,0 with 8-beat bursts and one idle cycle between
    req_v = 4'b1111;
    for (int i = 0; i < N; i++) addr_v[i] = AW'(i + 32);
    for (int c = 0; c <= 37; c++) begin
      run_cycle();
`ifndef ARB_PRIO0_EN
      case (c)
        0:  check("t1_gnt_c0",  64'(obs_gnt), 64'b0000);
        1:  check("t1_gnt_c1",  64'(obs_gnt), 64'b0001);
        8:  check("t1_gnt_c8",  64'(obs_gnt), 64'b0001);
        9:  check("t1_gnt_c9",  64'(obs_gnt), 64'b0000);
        10: check("t1_gnt_c10", 64'(obs_gnt), 64'b0010);
        19: check("t1_gnt_c19", 64'(obs_gnt), 64'b0100);
        28: check("t1_gnt_c28", 64'(obs_gnt), 64'b1000);
        37: check("t1_gnt_c37", 64'(obs_gnt), 64'b0001);
        default: ;
      endcase
`endif
    end
    set_idle(3);

    // Three writes from requester 2, then it drops req
    req_v      = 4'b0100;
    we_v       = 4'b0100;
    addr_v[2]  = AW'(5);
    wdata_v[2] = 32'hDEADBEEF;
    n_writes   = 0;
    for (int c = 0; c <= 5; c++) begin
      if (c == 4) req_v = '0;
      run_cycle();
      if (c == 4) check("t2_gnt_drop", 64'(obs_gnt), 64'b0100);
      if (c == 5) check("t2_gnt_after", 64'(obs_gnt), 64'b0000);
    end
    check("t2_writes", 64'(n_writes), 64'd3);

    // Requester 1 reads back address 5
    req_v     = 4'b0010;
    we_v      = '0;
    addr_v[1] = AW'(5);
    for (int c = 0; c <= 3; c++) begin
      if (c == 2) req_v = '0;
      run_cycle();
      if (c == 2) begin
        check("t3_rd_valid", 64'(obs_rv), 64'b0010);
        check("t3_rd_data", 64'(obs_rd), 64'hDEADBEEF);
      end
      if (c == 3) check("t3_rd_valid_off", 64'(obs_rv), 64'b0000);
    end
    set_idle(2);

    // Sole requester 3 regranted after every burst
    req_v = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      run_cycle();
      if (c == 8)  check("t4_gnt_c8",  64'(obs_gnt), 64'b1000);
      if (c == 9)  check("t4_gnt_c9",  64'(obs_gnt), 64'b0000);
      if (c == 10) check("t4_gnt_c10", 64'(obs_gnt), 64'b1000);
    end
    set_idle(2);

    // Reset in the middle of a read burst, then all request again
    req_v = 4'b0001;
    for (int c = 0; c <= 4; c++) run_cycle();
    do_reset();
    req_v = 4'b1111;
    run_cycle();
    check("t5_gnt_c0", 64'(obs_gnt), 64'b0000);
    run_cycle();
    check("t5_gnt_c1", 64'(obs_gnt), 64'b0001);
    set_idle(2);

`ifdef ARB_PRIO0_EN
    // Requester 0 preempts the round-robin order but leaves last_winner alone
    do_reset();
    req_v = 4'b1110;
    for (int c = 0; c <= 14; c++) begin
      if (c == 3)  req_v = 4'b1111;
      if (c == 12) req_v = 4'b1110;
      run_cycle();
      if (c == 1)  check("t6_gnt_1", 64'(obs_gnt), 64'b0010);
      if (c == 10) check("t6_gnt_0", 64'(obs_gnt), 64'b0001);
      if (c == 14) check("t6_gnt_2", 64'(obs_gnt), 64'b0100);
    end
    set_idle(2);
`endif

    // Randomized traffic: sticky requests, random ops on a small address window
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) req_v[i] = ~req_v[i];
        we_v[i]    = $urandom_range(1) == 1;
        addr_v[i]  = AW'($urandom_range(15));
        wdata_v[i] = $urandom;
      end
      if ($urandom_range(499) == 0) do_reset();
      else run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
